// File: rtl/pool_blk.sv
// Streaming POOL_SIZE x POOL_SIZE pooling (max or average) over CHANNELS raster-ordered maps.
// Horizontal partials per channel plus one row buffer of window partials per channel.
module pool_blk #(
  parameter int DATA_WIDTH = 48,
  parameter int CHANNELS   = 1,
  parameter int IN_SIZE    = 252,
  parameter int POOL_SIZE  = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_mode,
  input  logic                           i_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  output logic                           o_en,
  output logic [CHANNELS*DATA_WIDTH-1:0] o_data,
  output logic                           o_frame_done,
  output logic                           o_busy
);

  localparam int OUT_SIZE = IN_SIZE / POOL_SIZE;
  localparam int SHIFT    = 2 * $clog2(POOL_SIZE);
  localparam int SW       = DATA_WIDTH + SHIFT;
  localparam int LIM      = OUT_SIZE * POOL_SIZE;
  localparam int CW       = $clog2(IN_SIZE);
  localparam int PW       = $clog2(POOL_SIZE);
  localparam int OW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                         state_q;
  logic                           mode_q;
  logic [CW-1:0]                  col_q, row_q;
  logic signed [SW-1:0]           hpart_q [CHANNELS];
  logic signed [SW-1:0]           rbuf_q  [CHANNELS][OUT_SIZE];
  logic                           o_en_q, done_q;
  logic [CHANNELS*DATA_WIDTH-1:0] o_data_q;

  logic                           accept_s, contrib_s;
  logic                           first_col_s, last_col_s, first_row_s, last_row_s;
  logic [OW-1:0]                  bidx_s;
  logic signed [SW-1:0]           hpart_d [CHANNELS];
  logic signed [SW-1:0]           merge_d [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] res_s;

  function automatic logic signed [SW-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    return SW'(v);
  endfunction

  function automatic logic signed [SW-1:0] combine(input logic m, input logic signed [SW-1:0] a,
                                                   input logic signed [SW-1:0] b);
    if (m) return a + b;
    else   return (b > a) ? b : a;
  endfunction

  // Average: arithmetic shift floors toward -inf; the quotient always fits DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] finalize(input logic m, input logic signed [SW-1:0] v);
    logic signed [SW-1:0] sh;
    sh = v >>> SHIFT;
    if (m) return sh[DATA_WIDTH-1:0];
    else   return v[DATA_WIDTH-1:0];
  endfunction

  assign accept_s    = (state_q == S_RUN) && i_en && !i_start;
  assign contrib_s   = (32'(col_q) < LIM) && (32'(row_q) < LIM);
  assign first_col_s = (col_q[PW-1:0] == PW'(0));
  assign last_col_s  = (col_q[PW-1:0] == PW'(POOL_SIZE-1));
  assign first_row_s = (row_q[PW-1:0] == PW'(0));
  assign last_row_s  = (row_q[PW-1:0] == PW'(POOL_SIZE-1));
  assign bidx_s      = OW'(col_q >> PW);

  // Per-channel horizontal partial, vertical merge with the row buffer, and final result.
  always_comb begin
    res_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (first_col_s) begin
        hpart_d[c] = sext(i_data[c*DATA_WIDTH +: DATA_WIDTH]);
      end else begin
        hpart_d[c] = combine(mode_q, hpart_q[c], sext(i_data[c*DATA_WIDTH +: DATA_WIDTH]));
      end
      merge_d[c] = combine(mode_q, rbuf_q[c][bidx_s], hpart_d[c]);
      res_s[c*DATA_WIDTH +: DATA_WIDTH] = finalize(mode_q, merge_d[c]);
    end
  end

  // Frame control, counters, window state and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      o_en_q   <= 1'b0;
      done_q   <= 1'b0;
      o_data_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        hpart_q[c] <= '0;
        for (int b = 0; b < OUT_SIZE; b++) rbuf_q[c][b] <= '0;
      end
    end else begin
      o_en_q <= 1'b0;
      done_q <= 1'b0;
      if (i_start) begin
        state_q <= S_RUN;
        mode_q  <= i_mode;
        col_q   <= '0;
        row_q   <= '0;
      end else if (accept_s) begin
        if (col_q == CW'(IN_SIZE-1)) begin
          col_q <= '0;
          if (row_q == CW'(IN_SIZE-1)) begin
            row_q   <= '0;
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end else begin
          col_q <= col_q + 1'b1;
        end
        if (contrib_s) begin
          for (int c = 0; c < CHANNELS; c++) begin
            hpart_q[c] <= hpart_d[c];
            if (last_col_s && first_row_s) rbuf_q[c][bidx_s] <= hpart_d[c];
            else if (last_col_s && !last_row_s) rbuf_q[c][bidx_s] <= merge_d[c];
          end
          if (last_col_s && last_row_s) begin
            o_en_q   <= 1'b1;
            o_data_q <= res_s;
          end
        end
      end
    end
  end

  assign o_en         = o_en_q;
  assign o_data       = o_data_q;
  assign o_frame_done = done_q;
  assign o_busy       = (state_q == S_RUN);

endmodule

// File: doc/pool_blk.md
Name: pool_blk

Overview:
- Streaming 2-D pooling stage placed directly after conv_blk.
- Consumes conv_blk's raster-ordered output stream (o_en / o_conv_result) for CHANNELS parallel feature maps.
- Emits the pooled maps in raster order; max or average mode is selectable per frame.
- Replaces the fixed 2x2 max-pool option with a parametrised window, channel count and mode.

Parameters:
- DATA_WIDTH, 48, signed sample width per channel.
- CHANNELS, 1, number of parallel maps packed in i_data/o_data (channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]).
- IN_SIZE, 252, input map width = height.
- POOL_SIZE, 2, window side and stride; must be a power of two, >=2.
- localparam OUT_SIZE = IN_SIZE / POOL_SIZE (floor).
- localparam SHIFT = 2*log2(POOL_SIZE).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_start  in  1  one-cycle pulse: begin a new frame.
- i_mode  in  1  0 = max, 1 = average; sampled on i_start.
- i_en  in  1  input sample valid. No backpressure.
- i_data  in  CHANNELS*DATA_WIDTH  input samples, signed.
- o_en  out  1  output sample valid.
- o_data  out  CHANNELS*DATA_WIDTH  pooled samples, signed.
- o_frame_done  out  1  one-cycle pulse at end of frame.
- o_busy  out  1  frame in progress.

Behaviour:
- Reset (async): all outputs 0; counters, mode register, accumulators and row buffer cleared; state IDLE.
- States:
  - IDLE: o_busy=0; i_en ignored.
  - RUN: o_busy=1.
  - Transitions: i_start -> RUN from either state (clears counters, latches i_mode). RUN returns to IDLE after the IN_SIZE^2-th accepted sample.
- i_start in RUN aborts the frame: no output for partial windows; counters cleared. An i_en asserted in the same cycle as i_start is dropped.
- Counters:
  - col and row, 0..IN_SIZE-1, advanced only on accepted i_en.
  - col wraps to 0 and increments row. Gaps in i_en are allowed, any length.
- Window membership: a sample with col >= OUT_SIZE*POOL_SIZE or row >= OUT_SIZE*POOL_SIZE is counted but does not contribute (trailing partial windows dropped).
- Per channel, per window:
  - Horizontal partial register combines POOL_SIZE consecutive columns.
  - At the window's last column, the partial merges with row-buffer entry [col/POOL_SIZE] (depth OUT_SIZE per channel):
    - first window row: write;
    - middle rows: merge and write back;
    - last window row: merge and emit.
- Max mode: signed comparison.
- Average mode:
  - Sum in DATA_WIDTH+SHIFT bits, signed, no overflow possible.
  - Result = sum >>> SHIFT (arithmetic, rounds toward -inf), truncated to DATA_WIDTH (always in range).
- Latency: o_en asserts exactly 1 cycle after the accepted sample completing the window (row%P=P-1, col%P=P-1). o_data is held between pulses.
- o_frame_done: 1 cycle after the IN_SIZE^2-th sample, coincident with the final o_en when IN_SIZE % POOL_SIZE == 0.
- Output count per frame: OUT_SIZE^2 per frame, all channels simultaneous.
- Back-to-back frames: i_start may be asserted in the same cycle as o_frame_done.
- Reset mid-frame: immediate IDLE, all outputs 0, no further o_en.

Test Plan:
- IN_SIZE=4, P=2, C=1, max, inputs 0..15 consecutive -> o_en x4 with 5,7,13,15; o_frame_done with 4th o_en; each o_en 1 cycle after input 5,7,13,15.
- Same stream, avg -> 2,4,10,12. Same with all inputs negated, max -> -0,-2,-8,-10; avg window {-1,-2,-3,-4}... -> first output -3 (floor of -2.5).
- IN_SIZE=5, P=2, inputs 0..24, max -> 6,8,16,18 only; col/row 4 ignored; o_frame_done 1 cycle after sample 24, with no o_en in that cycle.
- C=2, channel1 = channel0 * -1, max, inputs 0..15 -> ch0 5,7,13,15; ch1 0,-2,-8,-10.
- Random 1-3 cycle gaps in i_en, IN_SIZE=8, P=4, avg, random 48-bit values incl. ±2^47 extremes -> 4 outputs matching the golden model; no overflow.
- Abort: i_start after 6 samples, then a fresh frame 0..15 -> only the new frame's 4 outputs. Also assert i_rst mid-frame -> all outputs 0 immediately, o_busy=0, i_en ignored until i_start.
